instr_fetch: RTL and testbench

Instruction fetch unit sitting directly upstream of `cpu`: it turns the CPU's byte program counter (`PC_out`) into a word request on the instruction-memory port and drives the CPU's `instruction` input. A one-entry fetch register holds the last fetched word with its address tag, so a repeated PC is a hit. A miss issues a req/gnt/rvalid transaction, and responses made stale by a PC change or flush are discarded. `instr_valid` tells the CPU when `instruction` belongs to the current PC; while it is low, `instruction` is a NOP.

---
 rtl/instr_fetch.sv | 112 +++++++++++
 tb/tb_instr_fetch.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one-entry tagged fetch register in front of a
// req/gnt/rvalid instruction memory, with stale-response discard on PC change or flush.
module instr_fetch #(
    parameter int unsigned ADDR_W = 9,
    parameter logic [31:0] NOP    = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       pc_in,
    input  logic              flush,
    output logic [31:0]       instruction,
    output logic              instr_valid,
    output logic              fetch_fault,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t              state_q, state_d;
    logic                tag_valid_q, tag_valid_d;
    logic [ADDR_W-1:0]   tag_q, tag_d;
    logic [31:0]         data_q, data_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic                kill_q, kill_d;
    logic                mem_req_q, mem_req_d;

    logic [ADDR_W-1:0]   pc_word;
    logic                hit;
    logic                pc_moved;

    assign pc_word     = pc_in[ADDR_W+1:2];
    assign fetch_fault = (pc_in[1:0] != 2'b00) || (pc_in[31:ADDR_W+2] != '0);
    assign hit         = tag_valid_q && !fetch_fault && (tag_q == pc_word);
    assign instr_valid = hit;
    assign instruction = hit ? data_q : NOP;
    assign mem_req     = mem_req_q;
    assign mem_addr    = req_addr_q;

    // Any PC move off the outstanding word, or a flush, makes the pending response stale.
    assign pc_moved    = (pc_word != req_addr_q) || flush;

    always_comb begin
        state_d     = state_q;
        tag_valid_d = tag_valid_q;
        tag_d       = tag_q;
        data_d      = data_q;
        req_addr_d  = req_addr_q;
        kill_d      = kill_q;
        mem_req_d   = mem_req_q;

        case (state_q)
            IDLE: begin
                if (!hit && !fetch_fault && !flush) begin
                    state_d    = REQ;
                    req_addr_d = pc_word;
                    kill_d     = 1'b0;
                    mem_req_d  = 1'b1;
                end
            end
            REQ: begin
                // The request is never retracted; a stale one is simply completed and dropped.
                if (pc_moved) kill_d = 1'b1;
                if (mem_gnt) begin
                    state_d   = WAIT;
                    mem_req_d = 1'b0;
                end
            end
            WAIT: begin
                if (pc_moved) kill_d = 1'b1;
                if (mem_rvalid) begin
                    if (!kill_q && !pc_moved) begin
                        data_d      = mem_rdata;
                        tag_d       = req_addr_q;
                        tag_valid_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        if (flush) tag_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tag_valid_q <= 1'b0;
            tag_q       <= '0;
            data_q      <= NOP;
            req_addr_q  <= '0;
            kill_q      <= 1'b0;
            mem_req_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tag_valid_q <= tag_valid_d;
            tag_q       <= tag_d;
            data_q      <= data_d;
            req_addr_q  <= req_addr_d;
            kill_q      <= kill_d;
            mem_req_q   <= mem_req_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: bench-side memory responder, transaction-level model of
// the fetch register checked every cycle, and directed hand-computed timing checks.
module tb_instr_fetch;

    localparam int unsigned ADDR_W = 9;
    localparam logic [31:0] NOP    = 32'h00000013;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       pc_in;
    logic              flush;
    logic [31:0]       instruction;
    logic              instr_valid;
    logic              fetch_fault;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [512];
    int   gnt_delay = 0;
    int   rv_delay  = 0;
    logic stray_rv  = 1'b0;
    logic stray_gnt = 1'b0;

    always #5 clk = ~clk;

    instr_fetch #(.ADDR_W(ADDR_W), .NOP(NOP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_in       (pc_in),
        .flush       (flush),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .fetch_fault (fetch_fault),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: grant after gnt_delay cycles of mem_req, data rv_delay cycles after the gnt cycle.
    int                gcnt = 0;
    int                rcnt = 0;
    logic              pend = 1'b0;
    logic [ADDR_W-1:0] paddr = '0;

    always @(posedge clk) begin
        #2;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        if (!rst_n) begin
            pend = 1'b0;
            gcnt = 0;
        end else begin
            if (pend) begin
                if (rcnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem[paddr];
                    pend       = 1'b0;
                end else begin
                    rcnt--;
                end
            end
            if (mem_req && !pend) begin
                if (gcnt >= gnt_delay) begin
                    mem_gnt = 1'b1;
                    pend    = 1'b1;
                    paddr   = mem_addr;
                    rcnt    = rv_delay;
                    gcnt    = 0;
                end else begin
                    gcnt++;
                end
            end
        end
        if (stray_rv) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hDEADBEEF;
        end
        if (stray_gnt) mem_gnt = 1'b1;
    end

    // Transaction-level model: the fetch register is whatever a clean response delivered.
    logic              mv = 1'b0;
    logic [ADDR_W-1:0] mtag = '0;
    logic [31:0]       mdata = NOP;
    logic              out = 1'b0, granted = 1'b0, clean = 1'b0;
    logic [ADDR_W-1:0] oaddr = '0;
    logic              pv = 1'b0, pflush = 1'b0, phit = 1'b0, pfault = 1'b0, preq = 1'b0;
    logic [31:0]       ppc = '0;
    logic              e_fault, e_hit, origin_ok;
    logic [ADDR_W-1:0] w;

    always @(negedge clk) begin
        if (!rst_n) begin
            mv      = 1'b0;
            out     = 1'b0;
            granted = 1'b0;
            pv      = 1'b0;
            preq    = 1'b0;
        end else begin
            w       = ADDR_W'(pc_in / 32'd4);
            e_fault = ((pc_in % 32'd4) != 0) || (pc_in >= 32'd2048);
            e_hit   = mv && !e_fault && (mtag == w);
            chk("m_fault", fetch_fault, e_fault);
            chk("m_valid", instr_valid, e_hit);
            chk("m_instr", instruction, e_hit ? mdata : NOP);

            if (mem_req && !preq) begin
                chk("m_one_outstanding", out, 1'b0);
                if (pv) begin
                    origin_ok = !pfault && !phit && !pflush && (mem_addr == ADDR_W'(ppc / 32'd4));
                    chk("m_req_origin", origin_ok, 1'b1);
                end
                out     = 1'b1;
                oaddr   = mem_addr;
                clean   = 1'b1;
                granted = 1'b0;
            end
            if (out && !granted) begin
                chk("m_req_held", mem_req, 1'b1);
                chk("m_addr_stable", mem_addr, oaddr);
            end else begin
                chk("m_no_req", mem_req, 1'b0);
            end

            if (out && ((w != oaddr) || flush)) clean = 1'b0;
            if (out && granted && mem_rvalid) begin
                if (clean) begin
                    mv    = 1'b1;
                    mtag  = oaddr;
                    mdata = mem[oaddr];
                end
                out     = 1'b0;
                granted = 1'b0;
            end
            if (out && mem_req && mem_gnt) granted = 1'b1;
            if (flush) mv = 1'b0;

            pv     = 1'b1;
            ppc    = pc_in;
            pflush = flush;
            phit   = e_hit;
            pfault = e_fault;
            preq   = mem_req;
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    int          pcs [3]   = '{4, 8, 12};
    logic [31:0] words [3] = '{32'h0C600E93, 32'h04CF4A13, 32'h0CB3C793};

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'h00000093 | (i << 20);
        mem[1] = 32'h02268193;
        mem[2] = 32'h04CF4A13;
        mem[3] = 32'h0CB3C793;

        rst_n = 1'b0; pc_in = 32'd0; flush = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;

        // Reset state
        @(negedge clk);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_instr", instruction, 32'h00000013);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_addr", mem_addr, 9'd0);
        chk("rst_fault", fetch_fault, 1'b0);
        next(); next();
        rst_n = 1'b1;
        repeat (5) next();

        // Zero-wait miss on PC 4, then hit
        pc_in = 32'd4;
        @(negedge clk); chk("zw_n_valid", instr_valid, 1'b0);
        next(); @(negedge clk);
        chk("zw_n1_req", mem_req, 1'b1);
        chk("zw_n1_addr", mem_addr, 9'd1);
        next(); @(negedge clk); chk("zw_n2_valid", instr_valid, 1'b0);
        next(); @(negedge clk);
        chk("zw_n3_valid", instr_valid, 1'b1);
        chk("zw_n3_instr", instruction, 32'h02268193);
        for (int k = 0; k < 4; k++) begin
            next(); @(negedge clk); chk("zw_hold_noreq", mem_req, 1'b0);
        end

        // Sequential stream with 2-cycle gnt delay, after rewriting word 1 and flushing
        mem[1] = 32'h0C600E93;
        gnt_delay = 2;
        next(); flush = 1'b1;
        @(negedge clk); chk("seq_flush_hit", instr_valid, 1'b1);
        next(); flush = 1'b0;
        @(negedge clk); chk("seq_flush_drop", instr_valid, 1'b0);
        for (int idx = 0; idx < 3; idx++) begin
            if (idx > 0) begin
                next(); pc_in = pcs[idx];
                @(negedge clk); chk("seq_miss", instr_valid, 1'b0);
            end
            for (int k = 1; k <= 5; k++) begin
                next(); @(negedge clk);
                if (k <= 3) begin
                    chk("seq_req", mem_req, 1'b1);
                    chk("seq_addr", mem_addr, 32'(pcs[idx] / 4));
                end
                chk("seq_valid", instr_valid, k == 5);
                if (k == 5) chk("seq_word", instruction, words[idx]);
            end
        end

        // Stale response: PC 8 -> 12 during WAIT
        gnt_delay = 0; rv_delay = 1;
        next(); pc_in = 32'd8; flush = 1'b1;
        @(negedge clk); chk("st_f_valid", instr_valid, 1'b0);
        next(); flush = 1'b0;
        @(negedge clk); chk("st_m_valid", instr_valid, 1'b0);
        next(); @(negedge clk);
        chk("st_req", mem_req, 1'b1);
        chk("st_addr", mem_addr, 9'd2);
        next(); pc_in = 32'd12;
        @(negedge clk); chk("st_wait_valid", instr_valid, 1'b0);
        next(); @(negedge clk); chk("st_rv_valid", instr_valid, 1'b0);
        next(); @(negedge clk);
        chk("st_idle_valid", instr_valid, 1'b0);
        chk("st_idle_req", mem_req, 1'b0);
        next(); @(negedge clk);
        chk("st_rereq", mem_req, 1'b1);
        chk("st_readdr", mem_addr, 9'd3);
        next(); next(); next(); @(negedge clk);
        chk("st_valid", instr_valid, 1'b1);
        chk("st_word", instruction, 32'h0CB3C793);

        // Faulting PCs
        rv_delay = 0;
        for (int f = 0; f < 2; f++) begin
            next(); pc_in = (f == 0) ? 32'd6 : 32'h00000800;
            for (int c = 0; c < 3; c++) begin
                if (c > 0) next();
                @(negedge clk);
                chk("flt_fault", fetch_fault, 1'b1);
                chk("flt_req", mem_req, 1'b0);
                chk("flt_instr", instruction, NOP);
            end
        end

        // Flush on a hit, then flush coincident with rvalid
        next(); pc_in = 32'd4;
        @(negedge clk); chk("fl_miss", instr_valid, 1'b0);
        next(); @(negedge clk); chk("fl_addr", mem_addr, 9'd1);
        next(); next(); @(negedge clk);
        chk("fl_hit", instr_valid, 1'b1);
        chk("fl_word", instruction, 32'h0C600E93);
        next(); flush = 1'b1;
        @(negedge clk); chk("fl_f_valid", instr_valid, 1'b1);
        next(); flush = 1'b0;
        @(negedge clk);
        chk("fl_drop", instr_valid, 1'b0);
        chk("fl_drop_req", mem_req, 1'b0);
        next(); @(negedge clk);
        chk("fl_rereq", mem_req, 1'b1);
        chk("fl_readdr", mem_addr, 9'd1);
        next(); flush = 1'b1;
        @(negedge clk); chk("fl_rv_valid", instr_valid, 1'b0);
        next(); flush = 1'b0;
        @(negedge clk); chk("fl_discard", instr_valid, 1'b0);
        next(); @(negedge clk);
        chk("fl_rereq2", mem_req, 1'b1);
        chk("fl_readdr2", mem_addr, 9'd1);
        next(); next(); @(negedge clk);
        chk("fl_valid2", instr_valid, 1'b1);
        chk("fl_word2", instruction, 32'h0C600E93);

        // Stray rvalid / gnt in IDLE are ignored
        next(); stray_rv = 1'b1;
        @(negedge clk); chk("sr_valid", instr_valid, 1'b1);
        next(); stray_rv = 1'b0; stray_gnt = 1'b1;
        @(negedge clk);
        chk("sr_word", instruction, 32'h0C600E93);
        chk("sr_req", mem_req, 1'b0);
        next(); stray_gnt = 1'b0;
        @(negedge clk);
        chk("sg_word", instruction, 32'h0C600E93);
        chk("sg_req", mem_req, 1'b0);

        // Reset mid-transaction, stray rvalid after release
        rv_delay = 2;
        next(); pc_in = 32'd8;
        @(negedge clk); chk("rm_miss", instr_valid, 1'b0);
        next(); @(negedge clk); chk("rm_req", mem_req, 1'b1);
        next(); rst_n = 1'b0; rv_delay = 0;
        #1;
        chk("rm_async_req", mem_req, 1'b0);
        chk("rm_async_instr", instruction, NOP);
        chk("rm_async_addr", mem_addr, 9'd0);
        next();
        next(); rst_n = 1'b1; stray_rv = 1'b1;
        @(negedge clk);
        chk("rm_r_valid", instr_valid, 1'b0);
        chk("rm_r_req", mem_req, 1'b0);
        next(); stray_rv = 1'b0;
        @(negedge clk);
        chk("rm_req2", mem_req, 1'b1);
        chk("rm_addr2", mem_addr, 9'd2);
        next(); next(); @(negedge clk);
        chk("rm_valid", instr_valid, 1'b1);
        chk("rm_word", instruction, 32'h04CF4A13);

        next();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
